// File: rtl/thread_scheduler_pkg.sv
// Shared constants and mask-FSM encoding for the barrel-pipeline thread scheduler.
package thread_scheduler_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    SCHED_IDLE    = 1'b0,
    SCHED_PENDING = 1'b1
  } sched_state_e;

endpackage

// File: rtl/thread_scheduler_if.sv
// Control/status bundle between the pipeline front end and the thread scheduler.
interface thread_scheduler_if #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int STATS_WIDTH       = 16
);
  logic                         mask_wren;
  logic [THREAD_COUNT-1:0]      mask_wdata;
  logic                         halt_req;
  logic [THREAD_ADDR_WIDTH-1:0] halt_thread;
  logic                         resume_req;
  logic [THREAD_ADDR_WIDTH-1:0] resume_thread;
  logic [THREAD_ADDR_WIDTH-1:0] previous_thread;
  logic [THREAD_ADDR_WIDTH-1:0] current_thread;
  logic [THREAD_ADDR_WIDTH-1:0] next_thread;
  logic                         thread_valid;
  logic                         round_start;
  logic [THREAD_COUNT-1:0]      active_mask;
  logic                         mask_busy;
  logic [THREAD_ADDR_WIDTH-1:0] stats_thread;
  logic [STATS_WIDTH-1:0]       stats_count;

  modport master (
    output mask_wren, mask_wdata, halt_req, halt_thread, resume_req, resume_thread, stats_thread,
    input  previous_thread, current_thread, next_thread, thread_valid, round_start,
           active_mask, mask_busy, stats_count
  );

  modport slave (
    input  mask_wren, mask_wdata, halt_req, halt_thread, resume_req, resume_thread, stats_thread,
    output previous_thread, current_thread, next_thread, thread_valid, round_start,
           active_mask, mask_busy, stats_count
  );
endinterface

// File: rtl/thread_scheduler_slot_counter.sv
// Round-robin slot counter: wraps by equality compare so THREAD_COUNT need not be a power of 2.
module thread_scheduler_slot_counter #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [THREAD_ADDR_WIDTH-1:0] previous_thread,
  output logic [THREAD_ADDR_WIDTH-1:0] current_thread,
  output logic [THREAD_ADDR_WIDTH-1:0] next_thread,
  output logic                         round_start
);
  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

  assign next_thread = (current_thread == LAST) ? '0 : current_thread + 1'b1;
  assign round_start = (current_thread == '0);

  // advance one slot per edge; previous is the slot just retired
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      current_thread  <= '0;
      previous_thread <= LAST;
    end else begin
      current_thread  <= next_thread;
      previous_thread <= current_thread;
    end
  end
endmodule

// File: rtl/thread_scheduler.sv
// Barrel-pipeline thread scheduler: slot sequencing, per-thread active mask,
// round-aligned mask writes, halt/resume, optional per-thread issue counters.
// Optional feature macro: THREAD_SCHEDULER_STATS_EN (issue counters + stats read port).
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int                     THREAD_COUNT      = 8,
  parameter int                     THREAD_ADDR_WIDTH = 3,
  parameter logic [THREAD_COUNT-1:0] RESET_ACTIVE_MASK = 'h01,
  parameter int                     STATS_WIDTH       = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  thread_scheduler_if.slave  bus
);
  localparam int AW = THREAD_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(THREAD_COUNT - 1);

  logic [AW-1:0]           cur;
  logic [AW-1:0]           prev;
  logic [AW-1:0]           nxt;
  logic                    rstart;
  logic                    boundary;
  logic                    valid;
  sched_state_e            state_q, state_d;
  logic [THREAD_COUNT-1:0] active_q, active_d;
  logic [THREAD_COUNT-1:0] pending_q, pending_d;

  thread_scheduler_slot_counter #(
    .THREAD_COUNT      (THREAD_COUNT),
    .THREAD_ADDR_WIDTH (AW)
  ) u_slot (
    .clock           (clock),
    .reset_n         (reset_n),
    .previous_thread (prev),
    .current_thread  (cur),
    .next_thread     (nxt),
    .round_start     (rstart)
  );

  // the edge leaving the last slot is the only place a pending mask lands
  assign boundary = (cur == LAST);

  // mask FSM next state: capture/overwrite while waiting for the round boundary
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      SCHED_IDLE: begin
        if (bus.mask_wren) begin
          state_d   = SCHED_PENDING;
          pending_d = bus.mask_wdata;
        end
      end
      SCHED_PENDING: begin
        if (boundary)           state_d   = SCHED_IDLE;
        else if (bus.mask_wren) pending_d = bus.mask_wdata;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // next mask: boundary apply first, then halt, then resume (resume wins)
  always_comb begin
    active_d = active_q;
    if (state_q == SCHED_PENDING && boundary)
      active_d = bus.mask_wren ? bus.mask_wdata : pending_q;
    for (int t = 0; t < THREAD_COUNT; t++) begin
      if (bus.halt_req   && bus.halt_thread   == AW'(t)) active_d[t] = LOW;
      if (bus.resume_req && bus.resume_thread == AW'(t)) active_d[t] = HIGH;
    end
  end

  // mask state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SCHED_IDLE;
      pending_q <= '0;
      active_q  <= RESET_ACTIVE_MASK;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // select the current slot's mask bit without an out-of-range index
  always_comb begin
    valid = LOW;
    for (int t = 0; t < THREAD_COUNT; t++)
      if (cur == AW'(t)) valid = active_q[t];
  end

  assign bus.previous_thread = prev;
  assign bus.current_thread  = cur;
  assign bus.next_thread     = nxt;
  assign bus.round_start     = rstart;
  assign bus.thread_valid    = valid;
  assign bus.active_mask     = active_q;
  assign bus.mask_busy       = (state_q == SCHED_PENDING);

`ifdef THREAD_SCHEDULER_STATS_EN
  logic [STATS_WIDTH-1:0] issue_cnt [THREAD_COUNT];
  logic [STATS_WIDTH-1:0] stats_q;

  // saturating issue counters and registered read (out-of-range reads 0)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < THREAD_COUNT; t++) issue_cnt[t] <= '0;
      stats_q <= '0;
    end else begin
      stats_q <= '0;
      for (int t = 0; t < THREAD_COUNT; t++) begin
        if (bus.stats_thread == AW'(t)) stats_q <= issue_cnt[t];
        if (cur == AW'(t) && active_q[t] && issue_cnt[t] != '1)
          issue_cnt[t] <= issue_cnt[t] + 1'b1;
      end
    end
  end

  assign bus.stats_count = stats_q;
`else
  logic unused_stats;
  assign unused_stats    = ^bus.stats_thread;
  assign bus.stats_count = '0;
`endif
endmodule
